key_debounce_ctrl: RTL and testbench

//  Avalon-MM slave controller for the push-button KEY inputs of the SoC. It synchronises and

---
 rtl/key_debounce_ctrl_pkg.sv | 16 +
 rtl/key_debounce_ctrl_if.sv | 22 ++
 rtl/key_debounce_ctrl_ch.sv | 88 ++++++++
 rtl/key_debounce_ctrl.sv | 109 ++++++++++
 tb/tb_key_debounce_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/key_debounce_ctrl_pkg.sv
// Shared definitions for the KEY debounce controller.
// Holds the register map addresses and the per-channel debounce state type.
// Imported by the channel sub-module and by the top level.
package key_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/key_debounce_ctrl_if.sv
// Avalon-MM slave bus for the KEY controller.
// Ports: address[1:0], chipselect, write_n (active-low), writedata[31:0], readdata[31:0].
// master modport drives the request, slave modport returns the registered read data.
interface key_debounce_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/key_debounce_ctrl_ch.sv
// One debounce channel: 2-flop synchroniser, STABLE/COUNT FSM and saturating counter.
// Latency: deb follows a stable pin change 2 + DEBOUNCE_CYCLES cycles later; no backpressure.
// Ports: clk, rst, pin (raw, active-low, async) -> deb, press_pulse (deb 1->0 this cycle), counting.
module key_debounce_ch
  import key_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic deb,
  output logic press_pulse,
  output logic counting
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic      sync1_q, sync1_d;
  logic      sync2_q, sync2_d;
  logic      deb_q, deb_d;
  ch_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser and debounced state reset to 1 so a held key is seen as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    case (state_q)
      ST_STABLE: begin
        if (sync2_q != deb_q) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (sync2_q == deb_q) begin
          // Input returned to the debounced level: treat as bounce.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          deb_d   = sync2_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // press_pulse is high in the cycle whose clock edge drops deb, so the edge
  // capture register sets on the same edge that deb updates.
  always_comb begin
    deb         = deb_q;
    counting    = (state_q == ST_COUNT);
    press_pulse = (state_q == ST_COUNT) && (sync2_q != deb_q) &&
                  (cnt_q == CNT_LAST) && !sync2_q;
  end

endmodule

// File: rtl/key_debounce_ctrl.sv
// Avalon-MM KEY controller: per-key debounce, DATA/IRQMASK/EDGECAP/STATUS registers, level irq.
// Latency: readdata registered (1 cycle); irq 1 cycle after edge/mask change; no backpressure.
// Ports: clk, reset (async high), bus (slave), in_port[WIDTH] active-low, irq. Macro KEYCTRL_IRQ_EN enables mask+irq.
module key_debounce_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic                clk,
  input  logic                reset,
  key_debounce_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0]    in_port,
  output logic                irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] counting;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (reset),
      .pin         (in_port[i]),
      .deb         (deb[i]),
      .press_pulse (press[i]),
      .counting    (counting[i])
    );
  end

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_rd;
  logic [31:0]      readdata_q, readdata_d;

  assign wr_en   = bus.chipselect && !bus.write_n;
  assign wr_bits = bus.writedata[WIDTH-1:0];

  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  // Set has priority over a same-cycle W1C clear.
  always_comb begin
    edge_d = edge_q;
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      edge_d = edge_q & ~wr_bits;
    end
    edge_d = edge_d | press;
  end

`ifdef KEYCTRL_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (bus.address == ADDR_IRQMASK)) begin
      mask_d = wr_bits;
    end
    irq_d = |(edge_q & mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign mask_rd = mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = deb;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_rd;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_q;
      ADDR_STATUS:  readdata_d[WIDTH-1:0] = counting;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_q     <= '0;
      readdata_q <= '0;
    end else begin
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Directed bench for key_debounce_ctrl with WIDTH=2, DEBOUNCE_CYCLES=8.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
// readdata shows a register's value as it was before the latest edge (1-cycle read latency).
module tb_key_debounce_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in_port;
  logic       irq;
  int         n_pass = 0;
  int         n_total = 0;
  logic       seen_status1;

  key_debounce_ctrl_if bus ();

  key_debounce_ctrl #(
    .WIDTH           (2),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick();
    data = bus.readdata;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    tick();
    bus.write_n    = 1'b1;
  endtask

  task automatic release_key0();
    in_port[0] = 1'b1;
    repeat (14) tick();
  endtask

  initial begin
    logic [31:0] d;
    reset          = 1'b1;
    in_port        = 2'b11;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // 1: reset values and idle reads
    #1;
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    rd(2'd0, d); check("idle_data", d, 32'h3);
    rd(2'd2, d); check("idle_edgecap", d, 32'h0);
    rd(2'd3, d); check("idle_status", d, 32'h0);
    check("idle_irq", {31'b0, irq}, 32'h0);

    // 2: key0 held low; deb drops at edge 10, visible on readdata after edge 11
    bus.address = 2'd0;
    in_port[0]  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) check("press_not_early", bus.readdata, 32'h3);
      if (k == 11) check("press_on_time", bus.readdata, 32'h2);
    end
    rd(2'd2, d); check("press_edgecap", d, 32'h1);
    rd(2'd0, d); check("press_data", d, 32'h2);
    release_key0();
    rd(2'd2, d); check("release_no_clear", d, 32'h1);
    wr(2'd2, 32'h1);
    rd(2'd2, d); check("w1c_clear", d, 32'h0);
    wr(2'd0, 32'h0);
    rd(2'd0, d); check("data_ro", d, 32'h3);

    // 3: key1 bouncing every 3 cycles never qualifies
    bus.address  = 2'd3;
    seen_status1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) in_port[1] = ~in_port[1];
      tick();
      if (bus.readdata[1]) seen_status1 = 1'b1;
    end
    in_port[1] = 1'b1;
    repeat (12) tick();
    check("bounce_status_seen", {31'b0, seen_status1}, 32'h1);
    rd(2'd0, d); check("bounce_data", d, 32'h3);
    rd(2'd2, d); check("bounce_edgecap", d, 32'h0);
    rd(2'd3, d); check("bounce_status_idle", d, 32'h0);

`ifdef KEYCTRL_IRQ_EN
    // 4: masked interrupt, edge sets at edge 10, irq follows at edge 11
    wr(2'd1, 32'h1);
    rd(2'd1, d); check("mask_rd", d, 32'h1);
    in_port[0] = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 10) check("irq_not_early", {31'b0, irq}, 32'h0);
      if (k == 11) check("irq_set", {31'b0, irq}, 32'h1);
    end
    wr(2'd2, 32'h1);
    check("irq_hold_on_clear_edge", {31'b0, irq}, 32'h1);
    tick();
    check("irq_cleared", {31'b0, irq}, 32'h0);
    release_key0();
`else
    // 4: no mask flops; irq stays low while EDGECAP still captures
    wr(2'd1, 32'h1);
    rd(2'd1, d); check("mask_rd_zero", d, 32'h0);
    in_port[0] = 1'b0;
    repeat (12) tick();
    check("irq_tied_low", {31'b0, irq}, 32'h0);
    rd(2'd2, d); check("poll_edgecap", d, 32'h1);
    wr(2'd2, 32'h1);
    release_key0();
`endif
    rd(2'd2, d); check("pre5_edgecap", d, 32'h0);

    // 5: W1C in the cycle whose edge sets edge[0]; set wins
    in_port[0] = 1'b0;
    repeat (9) tick();
    wr(2'd2, 32'h1);
    rd(2'd2, d); check("set_beats_clear", d, 32'h1);
    wr(2'd2, 32'h1);
    release_key0();
    rd(2'd2, d); check("pre6_edgecap", d, 32'h0);

    // 6: reset with key0 mid-count (cnt=4), key held low through reset
    in_port[0] = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    check("midrst_readdata", bus.readdata, 32'h0);
    tick();
    bus.address    = 2'd2;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    reset          = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1)  check("postrst_edge_zero", bus.readdata, 32'h0);
      if (k == 10) check("postrst_no_early", bus.readdata, 32'h0);
      if (k == 11) check("postrst_fresh_press", bus.readdata, 32'h1);
    end
    rd(2'd0, d); check("postrst_data", d, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
